// File: rtl/clk_div_multi_if.sv
// Configuration and output bundle for the multi-channel clock divider.
// No latency of its own; carries enables, a one-shot config write and the divided outputs.
// No backpressure: a strobed config write is always accepted.
interface clk_div_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]  en;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  cfg_pending;

  // Stimulus side: drives enables and config, observes divided outputs.
  modport master (
    output en, cfg_we, cfg_ch, cfg_div, cfg_mode,
    input  clk_out, tick, cfg_pending
  );

  // Divider side.
  modport slave (
    input  en, cfg_we, cfg_ch, cfg_div, cfg_mode,
    output clk_out, tick, cfg_pending
  );
endinterface

// File: rtl/clk_div_multi.sv
// N_CH independent integer clock dividers with shadowed, glitch-free divisor/mode updates.
// Latency: clk_out/tick are registered, one clk_in edge after the counter state that produces them.
// No backpressure: config writes land in a shadow and are applied at the next period wrap or while disabled.
module clk_div_multi #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic           clk_in,
  input  logic           reset,
  clk_div_multi_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic             mode;   // 0 = square, 1 = pulse
  } ch_cfg_t;

  localparam ch_cfg_t RST_CFG = '{div: CNT_W'(DEF_DIV), mode: 1'b0};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_cfg_t          act;
    ch_cfg_t          shd;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] de;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap;
    logic             apply;
    logic             hit;
    logic             clk_q;
    logic             tick_q;
    logic             pend_q;

    // Effective divisor (square needs >=2 to have both phases), wrap decode and next count.
    always_comb begin
      if (act.mode) begin
        de = (act.div < ONE) ? ONE : act.div;
      end else begin
        de = (act.div < TWO) ? TWO : act.div;
      end
      half    = (de >> 1) + CNT_W'(de[0]);
      wrap    = bus.en[i] && (cnt == de - ONE);
      cnt_nxt = wrap ? '0 : cnt + ONE;
      // Shadow is safe to apply at a period boundary or whenever the channel is idle.
      apply   = wrap || !bus.en[i];
      // Out-of-range channel numbers never match any i and are dropped.
      hit     = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
    end

    // Counter, registered outputs and shadow/active configuration; a write on an
    // apply edge lands in the shadow after the old shadow was promoted, so pending stays set.
    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        act    <= RST_CFG;
        shd    <= RST_CFG;
      end else begin
        if (!bus.en[i]) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          cnt    <= cnt_nxt;
          tick_q <= wrap;
          clk_q  <= act.mode ? wrap : (cnt_nxt < half);
        end
        if (apply) begin
          act    <= shd;
          pend_q <= 1'b0;
        end
        if (hit) begin
          shd    <= '{div: bus.cfg_div, mode: bus.cfg_mode};
          pend_q <= 1'b1;
        end
      end
    end

    assign bus.clk_out[i]     = clk_q;
    assign bus.tick[i]        = tick_q;
    assign bus.cfg_pending[i] = pend_q;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a behavioural model pushes expected outputs per edge.
// Six channels are used so that cfg_ch can address a non-existent channel.
// Directed window counts (ticks / high cycles) back up the per-edge comparisons.
module tb_clk_div_multi;
  localparam int N_CH    = 6;
  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 2;
  localparam int CH_W    = $clog2(N_CH);

  logic clk_in = 1'b0;
  logic reset;

  clk_div_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  clk_div_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [N_CH-1:0] clk_out;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] pend;
  } exp_t;

  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [N_CH-1:0]  cur_en;

  logic [CNT_W-1:0] m_cnt   [N_CH];
  logic [CNT_W-1:0] m_div_a [N_CH];
  logic [CNT_W-1:0] m_div_s [N_CH];
  logic             m_mode_a[N_CH];
  logic             m_mode_s[N_CH];
  logic             m_pend  [N_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_cnt[i]    = '0;
      m_div_a[i]  = CNT_W'(DEF_DIV);
      m_div_s[i]  = CNT_W'(DEF_DIV);
      m_mode_a[i] = 1'b0;
      m_mode_s[i] = 1'b0;
      m_pend[i]   = 1'b0;
    end
  endtask

  // One clock edge of the reference behaviour; square high iff 2*count < De.
  task automatic model_step(input logic [N_CH-1:0] en, input logic we, input int ch,
                            input logic [CNT_W-1:0] d, input logic md);
    exp_t e;
    e = '0;
    for (int i = 0; i < N_CH; i++) begin
      int de;
      bit upd;
      upd = 1'b1;
      if (en[i]) begin
        if (m_mode_a[i]) de = (m_div_a[i] == 0) ? 1 : int'(m_div_a[i]);
        else             de = (m_div_a[i] < 2)  ? 2 : int'(m_div_a[i]);
        if (int'(m_cnt[i]) == de - 1) begin
          m_cnt[i]  = '0;
          e.tick[i] = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1'b1;
          upd      = 1'b0;
        end
        e.clk_out[i] = m_mode_a[i] ? e.tick[i] : ((2 * int'(m_cnt[i])) < de);
      end else begin
        m_cnt[i] = '0;
      end
      if (upd) begin
        m_div_a[i]  = m_div_s[i];
        m_mode_a[i] = m_mode_s[i];
        m_pend[i]   = 1'b0;
      end
      if (we && ch == i) begin
        m_div_s[i]  = d;
        m_mode_s[i] = md;
        m_pend[i]   = 1'b1;
      end
      e.pend[i] = m_pend[i];
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [N_CH-1:0] en, input logic we, input int ch,
                      input int d, input logic md);
    exp_t e;
    @(negedge clk_in);
    bus.en       = en;
    bus.cfg_we   = we;
    bus.cfg_ch   = CH_W'(ch);
    bus.cfg_div  = CNT_W'(d);
    bus.cfg_mode = md;
    model_step(en, we, ch, CNT_W'(d), md);
    @(posedge clk_in);
    #1;
    check("sb_depth", 32'(sb_q.size()), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("clk_out", 32'(bus.clk_out), 32'(e.clk_out));
      check("tick", 32'(bus.tick), 32'(e.tick));
      check("cfg_pending", 32'(bus.cfg_pending), 32'(e.pend));
    end
    bus.cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(cur_en, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic window(input int n, input int ch, output int hi, output int tk);
    hi = 0;
    tk = 0;
    repeat (n) begin
      step(cur_en, 1'b0, 0, 0, 1'b0);
      hi += int'(bus.clk_out[ch]);
      tk += int'(bus.tick[ch]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  hi;
    int  tk;
    bit  found;
    bus.en       = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_div  = '0;
    bus.cfg_mode = 1'b0;
    cur_en       = '0;
    reset        = 1'b1;
    model_reset();
    #3;
    check("rst_clk_out", 32'(bus.clk_out), 0);
    check("rst_tick", 32'(bus.tick), 0);
    check("rst_pending", 32'(bus.cfg_pending), 0);
    @(posedge clk_in);
    #2 reset = 1'b0;

    // Defaults: period 2 everywhere.
    cur_en = '1;
    window(8, 0, hi, tk);
    check("def_tick0", tk, 4);
    check("def_hi0", hi, 4);

    // Ch0 square D=5.
    step(cur_en, 1'b1, 0, 5, 1'b0);
    idle(6);
    window(10, 0, hi, tk);
    check("d5_tick0", tk, 2);
    check("d5_hi0", hi, 6);

    // Ch1 pulse D=4, then pulse D=0.
    step(cur_en, 1'b1, 1, 4, 1'b1);
    idle(6);
    window(8, 1, hi, tk);
    check("p4_tick1", tk, 2);
    check("p4_hi1", hi, 2);
    step(cur_en, 1'b1, 1, 0, 1'b1);
    idle(6);
    window(4, 1, hi, tk);
    check("p0_tick1", tk, 4);
    check("p0_hi1", hi, 4);

    // Ch2 last write wins, then a write exactly on a wrap edge.
    step(cur_en, 1'b1, 2, 3, 1'b0);
    step(cur_en, 1'b1, 2, 7, 1'b0);
    check("d7_pend_set", 32'(bus.cfg_pending[2]), 1);
    idle(10);
    check("d7_pend_clr", 32'(bus.cfg_pending[2]), 0);
    window(14, 2, hi, tk);
    check("d7_tick2", tk, 2);
    check("d7_hi2", hi, 8);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_cnt[2] == CNT_W'(6)) begin
        step(cur_en, 1'b1, 2, 3, 1'b0);
        found = 1'b1;
      end else begin
        idle(1);
      end
    end
    check("wrap_found", 32'(found), 1);
    check("wrapw_pend", 32'(bus.cfg_pending[2]), 1);
    idle(6);
    check("wrapw_pend_hold", 32'(bus.cfg_pending[2]), 1);
    idle(1);
    check("wrapw_pend_clr", 32'(bus.cfg_pending[2]), 0);

    // Ch3 disabled with a pending D=6, then re-enabled.
    step(cur_en, 1'b1, 3, 6, 1'b0);
    cur_en[3] = 1'b0;
    step(cur_en, 1'b0, 0, 0, 1'b0);
    check("dis_clk3", 32'(bus.clk_out[3]), 0);
    check("dis_pend3", 32'(bus.cfg_pending[3]), 0);
    idle(3);
    cur_en[3] = 1'b1;
    window(12, 3, hi, tk);
    check("d6_tick3", tk, 2);
    check("d6_hi3", hi, 6);

    // Reset mid-period with pending writes.
    step(cur_en, 1'b1, 0, 9, 1'b1);
    step(cur_en, 1'b1, 4, 11, 1'b0);
    check("pre_rst_pend", 32'(bus.cfg_pending & 6'b010001), 32'h11);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_clk_out", 32'(bus.clk_out), 0);
    check("mid_rst_tick", 32'(bus.tick), 0);
    check("mid_rst_pending", 32'(bus.cfg_pending), 0);
    model_reset();
    @(posedge clk_in);
    #2 reset = 1'b0;
    window(4, 0, hi, tk);
    check("post_rst_tick0", tk, 2);
    check("post_rst_hi0", hi, 2);
    check("post_rst_pend", 32'(bus.cfg_pending), 0);

    // Writes to non-existent channels are ignored.
    step(cur_en, 1'b1, N_CH, 9, 1'b1);
    check("oob_pend", 32'(bus.cfg_pending), 0);
    step(cur_en, 1'b1, 7, 3, 1'b1);
    idle(4);
    check("oob_pend2", 32'(bus.cfg_pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
